// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues req/ack reads to instruction memory,
// and computes the next PC from the sequential or branch offset when decode consumes.
module fetch_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TMR_W   = 5
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startpc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_imm,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [63:0] instr_pc,
  output logic [25:0] imm26,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t             state;
  logic [63:0]        pc;
  logic [TMR_W-1:0]   timer;
  logic [63:0]        next_pc;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign imm26     = instr[25:0];

  // Both adds wrap modulo 2^64; misalignment is caught on the result.
  always_comb begin
    next_pc = '0;
    if (branch_taken) next_pc = instr_pc + branch_imm;
    else              next_pc = instr_pc + 64'd4;
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      pc          <= startpc;
      timer       <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      if (startpc[1:0] != 2'b00) begin
        state <= S_FAULT;
        fault <= 1'b1;
      end else begin
        state <= S_REQ;
        fault <= 1'b0;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            timer       <= '0;
            state       <= S_VALID;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_VALID: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              pc    <= next_pc;
              state <= S_REQ;
            end else begin
              fault <= 1'b1;
              state <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
          fault       <= 1'b1;
          instr_valid <= 1'b0;
        end
        default: begin
          fault       <= 1'b1;
          instr_valid <= 1'b0;
          state       <= S_FAULT;
        end
      endcase
    end
  end

endmodule
